// File: rtl/ahb_lite_master_fsm_pkg.sv
// Shared AHB-Lite encodings (HTRANS, HSIZE, HBURST, HRESP) and the alignment helper
// used by the ahb_lite_master_fsm initiator.
package ahb_lite_master_fsm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE     = 3'd0;
  localparam logic [2:0] HSIZE_HALFWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD     = 3'd2;
  localparam logic [2:0] HBURST_SINGLE  = 3'd0;
  localparam logic       HRESP_OKAY     = 1'b0;
  localparam logic       HRESP_ERROR    = 1'b1;

  // Sizes wider than a word cannot be carried on a 32-bit bus, so they count as misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb, input logic [2:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      HSIZE_BYTE:     bad = 1'b0;
      HSIZE_HALFWORD: bad = addr_lsb[0];
      HSIZE_WORD:     bad = (addr_lsb != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lite_master_fsm_if.sv
// Command/response handshake plus AHB-Lite manager signals, with master (initiator)
// and slave (environment) views.
interface ahb_lite_master_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import ahb_lite_master_fsm_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_write;
  logic [2:0]        cmd_size;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  htrans_e           HTRANS;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_size,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_size,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
  );

endinterface

// File: rtl/ahb_lite_master_fsm_cmd_replay.sv
// ahb_lite_cmd_replay: single-entry holding register for an address phase cancelled
// by an ERROR response, kept until it is reissued on the bus.
module ahb_lite_cmd_replay
  import ahb_lite_master_fsm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_reissue,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_write,
  input  logic [2:0]        i_size,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_write,
  output logic [2:0]        o_size
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [2:0]        r_size;

  // Load and reissue never coincide: loading happens on a stalled edge, reissue on a ready one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_size  <= HSIZE_BYTE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_write <= i_write;
      r_size  <= i_size;
    end else if (i_reissue) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_write = r_write;
  assign o_size  = r_size;

endmodule

// File: rtl/ahb_lite_master_fsm.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, pipelined NONSEQ transfers out.
// Define AHB_LITE_MASTER_ALIGN_CHECK_EN to reject misaligned/oversized commands without issuing them.
module ahb_lite_master_fsm
  import ahb_lite_master_fsm_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb_lite_master_fsm_if.master bus
);

  htrans_e           r_htrans,    w_htrans_nxt;
  logic [ADDR_W-1:0] r_haddr,     w_haddr_nxt;
  logic              r_hwrite,    w_hwrite_nxt;
  logic [2:0]        r_hsize,     w_hsize_nxt;
  logic [DATA_W-1:0] r_awdata,    w_awdata_nxt;
  logic [DATA_W-1:0] r_hwdata,    w_hwdata_nxt;
  logic              r_dp_valid,  w_dp_valid_nxt;
  logic              r_dp_write,  w_dp_write_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_err,   w_rsp_err_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

  logic              w_resp_error;
  logic              w_err_first;
  logic              w_complete;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_issue_new;
  logic              w_reissue;
  logic              w_replay_load;
  logic              w_replay_valid;
  logic [ADDR_W-1:0] w_replay_addr;
  logic [DATA_W-1:0] w_replay_wdata;
  logic              w_replay_write;
  logic [2:0]        w_replay_size;

  assign w_resp_error = (bus.HRESP == HRESP_ERROR);
  assign w_err_first  = r_dp_valid && w_resp_error && !bus.HREADY;
  assign w_complete   = r_dp_valid && bus.HREADY;
  assign w_reissue    = bus.HREADY && w_replay_valid;

`ifdef AHB_LITE_MASTER_ALIGN_CHECK_EN
  logic r_rej_pending, w_rej_pending_nxt;
  logic w_misaligned;
  logic w_rej_emit;

  // A pending rejection holds off new commands so every outstanding transfer is older than it.
  assign w_misaligned = is_misaligned(bus.cmd_addr[1:0], bus.cmd_size);
  assign w_cmd_ready  = bus.HREADY && !w_err_first && !w_replay_valid && !r_rej_pending;
  assign w_accept     = bus.cmd_valid && w_cmd_ready;
  assign w_issue_new  = w_accept && !w_misaligned;
  assign w_rej_emit   = r_rej_pending && !r_dp_valid && (r_htrans == HTRANS_IDLE) && !w_replay_valid;
`else
  assign w_cmd_ready  = bus.HREADY && !w_err_first && !w_replay_valid;
  assign w_accept     = bus.cmd_valid && w_cmd_ready;
  assign w_issue_new  = w_accept;
`endif

  ahb_lite_cmd_replay #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_replay (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .i_load    (w_replay_load),
    .i_reissue (w_reissue),
    .i_addr    (r_haddr),
    .i_wdata   (r_awdata),
    .i_write   (r_hwrite),
    .i_size    (r_hsize),
    .o_valid   (w_replay_valid),
    .o_addr    (w_replay_addr),
    .o_wdata   (w_replay_wdata),
    .o_write   (w_replay_write),
    .o_size    (w_replay_size)
  );

  always_comb begin
    w_htrans_nxt    = r_htrans;
    w_haddr_nxt     = r_haddr;
    w_hwrite_nxt    = r_hwrite;
    w_hsize_nxt     = r_hsize;
    w_awdata_nxt    = r_awdata;
    w_hwdata_nxt    = r_hwdata;
    w_dp_valid_nxt  = r_dp_valid;
    w_dp_write_nxt  = r_dp_write;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_replay_load   = 1'b0;
`ifdef AHB_LITE_MASTER_ALIGN_CHECK_EN
    w_rej_pending_nxt = r_rej_pending;
`endif

    // First ERROR cycle: park any pending address phase and drop HTRANS to IDLE.
    if (w_err_first) begin
      if (r_htrans == HTRANS_NONSEQ) begin
        w_replay_load = 1'b1;
        w_htrans_nxt  = HTRANS_IDLE;
      end
    end else if (bus.HREADY) begin
      w_dp_valid_nxt = (r_htrans == HTRANS_NONSEQ);
      w_dp_write_nxt = r_hwrite;
      if (r_htrans == HTRANS_NONSEQ) begin
        w_hwdata_nxt = r_awdata;
      end
      if (w_reissue) begin
        w_htrans_nxt = HTRANS_NONSEQ;
        w_haddr_nxt  = w_replay_addr;
        w_hwrite_nxt = w_replay_write;
        w_hsize_nxt  = w_replay_size;
        w_awdata_nxt = w_replay_wdata;
      end else if (w_issue_new) begin
        w_htrans_nxt = HTRANS_NONSEQ;
        w_haddr_nxt  = bus.cmd_addr;
        w_hwrite_nxt = bus.cmd_write;
        w_hsize_nxt  = bus.cmd_size;
        w_awdata_nxt = bus.cmd_wdata;
      end else begin
        w_htrans_nxt = HTRANS_IDLE;
      end
    end

    if (w_complete) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_err_nxt   = w_resp_error;
      w_rsp_rdata_nxt = (r_dp_write || w_resp_error) ? '0 : bus.HRDATA;
    end

`ifdef AHB_LITE_MASTER_ALIGN_CHECK_EN
    if (w_rej_emit) begin
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_err_nxt     = 1'b1;
      w_rej_pending_nxt = 1'b0;
    end else if (w_accept && w_misaligned) begin
      w_rej_pending_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= HSIZE_BYTE;
      r_awdata    <= '0;
      r_hwdata    <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef AHB_LITE_MASTER_ALIGN_CHECK_EN
      r_rej_pending <= 1'b0;
`endif
    end else begin
      r_htrans    <= w_htrans_nxt;
      r_haddr     <= w_haddr_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hsize     <= w_hsize_nxt;
      r_awdata    <= w_awdata_nxt;
      r_hwdata    <= w_hwdata_nxt;
      r_dp_valid  <= w_dp_valid_nxt;
      r_dp_write  <= w_dp_write_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
`ifdef AHB_LITE_MASTER_ALIGN_CHECK_EN
      r_rej_pending <= w_rej_pending_nxt;
`endif
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = r_hsize;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HTRANS    = r_htrans;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master_fsm.sv
// Directed self-checking bench for ahb_lite_master_fsm; acts as command source and AHB slave.
// Define AHB_LITE_MASTER_ALIGN_CHECK_EN to exercise the misaligned-command rejection path.
module tb_ahb_lite_master_fsm;

  logic clk;
  logic resetN;
  int   vectorCount = 0;
  int   missCount   = 0;

  ahb_lite_master_fsm_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

  ahb_lite_master_fsm #(
    .HPROT_VAL (4'b0011),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .HCLK    (clk),
    .HRESETn (resetN),
    .bus     (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic write, input logic [2:0] size);
    busIf.cmd_valid = valid;
    busIf.cmd_addr  = addr;
    busIf.cmd_wdata = wdata;
    busIf.cmd_write = write;
    busIf.cmd_size  = size;
  endtask

  task automatic driveSlave(input logic ready, input logic resp, input logic [31:0] rdata);
    busIf.HREADY = ready;
    busIf.HRESP  = resp;
    busIf.HRDATA = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    driveSlave(1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    checkOutput("rst_htrans",    32'(busIf.HTRANS),    32'd0);
    checkOutput("rst_haddr",     busIf.HADDR,          32'h0);
    checkOutput("rst_hwrite",    32'(busIf.HWRITE),    32'd0);
    checkOutput("rst_hsize",     32'(busIf.HSIZE),     32'd0);
    checkOutput("rst_hwdata",    busIf.HWDATA,         32'h0);
    checkOutput("rst_rsp_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", busIf.rsp_rdata,      32'h0);
    checkOutput("rst_rsp_err",   32'(busIf.rsp_err),   32'd0);
    checkOutput("rst_hburst",    32'(busIf.HBURST),    32'd0);
    checkOutput("rst_hprot",     32'(busIf.HPROT),     32'd3);
    checkOutput("rst_hmastlock", 32'(busIf.HMASTLOCK), 32'd0);

    @(negedge clk);
    resetN = 1'b1;
    tick();
    checkOutput("idle_cmd_ready", 32'(busIf.cmd_ready), 32'd1);

    $display("[TB] write halfword 0x00");
    applyStimulus(1'b1, 32'h0, 32'h0000_00AA, 1'b1, 3'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    checkOutput("t1_htrans_nonseq", 32'(busIf.HTRANS),    32'd2);
    checkOutput("t1_haddr",         busIf.HADDR,          32'h0);
    checkOutput("t1_hsize",         32'(busIf.HSIZE),     32'd1);
    checkOutput("t1_hwrite",        32'(busIf.HWRITE),    32'd1);
    checkOutput("t1_rsp_early",     32'(busIf.rsp_valid), 32'd0);
    tick();
    checkOutput("t1_hwdata",        busIf.HWDATA,         32'h0000_00AA);
    checkOutput("t1_htrans_idle",   32'(busIf.HTRANS),    32'd0);
    checkOutput("t1_rsp_dphase",    32'(busIf.rsp_valid), 32'd0);
    tick();
    checkOutput("t1_rsp_valid",     32'(busIf.rsp_valid), 32'd1);
    checkOutput("t1_rsp_err",       32'(busIf.rsp_err),   32'd0);
    checkOutput("t1_rsp_rdata",     busIf.rsp_rdata,      32'h0);
    tick();
    checkOutput("t1_rsp_pulse",     32'(busIf.rsp_valid), 32'd0);

    $display("[TB] read byte 0x02 with two wait states, then write/read 0x04 back to back");
    applyStimulus(1'b1, 32'h2, 32'h0, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    checkOutput("t2_htrans_nonseq", 32'(busIf.HTRANS), 32'd2);
    checkOutput("t2_haddr",         busIf.HADDR,       32'h2);
    checkOutput("t2_hsize",         32'(busIf.HSIZE),  32'd0);
    checkOutput("t2_hwrite",        32'(busIf.HWRITE), 32'd0);
    tick();
    driveSlave(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h4, 32'h0000_FFFF, 1'b1, 3'd2);
    #1;
    checkOutput("t2_ready_wait",    32'(busIf.cmd_ready), 32'd0);
    tick();
    checkOutput("t2_htrans_wait",   32'(busIf.HTRANS),    32'd0);
    checkOutput("t2_haddr_wait",    busIf.HADDR,          32'h2);
    checkOutput("t2_rsp_wait",      32'(busIf.rsp_valid), 32'd0);
    tick();
    checkOutput("t2_haddr_wait2",   busIf.HADDR,          32'h2);
    driveSlave(1'b1, 1'b0, 32'h00AA_0000);
    tick();
    checkOutput("t2_rsp_valid",     32'(busIf.rsp_valid), 32'd1);
    checkOutput("t2_rsp_rdata",     busIf.rsp_rdata,      32'h00AA_0000);
    checkOutput("t2_rsp_err",       32'(busIf.rsp_err),   32'd0);
    checkOutput("t3_wr_htrans",     32'(busIf.HTRANS),    32'd2);
    checkOutput("t3_wr_haddr",      busIf.HADDR,          32'h4);
    checkOutput("t3_wr_hwrite",     32'(busIf.HWRITE),    32'd1);
    checkOutput("t3_wr_hsize",      32'(busIf.HSIZE),     32'd2);
    applyStimulus(1'b1, 32'h4, 32'h0, 1'b0, 3'd2);
    driveSlave(1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    checkOutput("t3_rd_htrans",     32'(busIf.HTRANS),    32'd2);
    checkOutput("t3_rd_haddr",      busIf.HADDR,          32'h4);
    checkOutput("t3_rd_hwrite",     32'(busIf.HWRITE),    32'd0);
    checkOutput("t3_wr_hwdata",     busIf.HWDATA,         32'h0000_FFFF);
    checkOutput("t3_rsp_gap",       32'(busIf.rsp_valid), 32'd0);
    driveSlave(1'b1, 1'b0, 32'h0000_FFFF);
    tick();
    checkOutput("t3_wr_rsp_valid",  32'(busIf.rsp_valid), 32'd1);
    checkOutput("t3_wr_rsp_rdata",  busIf.rsp_rdata,      32'h0);
    checkOutput("t3_htrans_idle",   32'(busIf.HTRANS),    32'd0);
    tick();
    checkOutput("t3_rd_rsp_valid",  32'(busIf.rsp_valid), 32'd1);
    checkOutput("t3_rd_rsp_rdata",  busIf.rsp_rdata,      32'h0000_FFFF);
    checkOutput("t3_rd_rsp_err",    32'(busIf.rsp_err),   32'd0);

    $display("[TB] ERROR on write 0x08 with read 0x0C in address phase");
    driveSlave(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h8, 32'h1234_5678, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b1, 32'hC, 32'h0, 1'b0, 3'd2);
    checkOutput("t4_wr_htrans",     32'(busIf.HTRANS), 32'd2);
    checkOutput("t4_wr_haddr",      busIf.HADDR,       32'h8);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    driveSlave(1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("t4_ready_err1",    32'(busIf.cmd_ready), 32'd0);
    checkOutput("t4_rd_htrans",     32'(busIf.HTRANS),    32'd2);
    checkOutput("t4_rd_haddr",      busIf.HADDR,          32'hC);
    checkOutput("t4_wr_hwdata",     busIf.HWDATA,         32'h1234_5678);
    tick();
    checkOutput("t4_htrans_cancel", 32'(busIf.HTRANS),    32'd0);
    checkOutput("t4_rsp_err1",      32'(busIf.rsp_valid), 32'd0);
    checkOutput("t4_hwdata_hold",   busIf.HWDATA,         32'h1234_5678);
    driveSlave(1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    checkOutput("t4_err_rsp_valid", 32'(busIf.rsp_valid), 32'd1);
    checkOutput("t4_err_rsp_err",   32'(busIf.rsp_err),   32'd1);
    checkOutput("t4_err_rsp_rdata", busIf.rsp_rdata,      32'h0);
    checkOutput("t4_replay_htrans", 32'(busIf.HTRANS),    32'd2);
    checkOutput("t4_replay_haddr",  busIf.HADDR,          32'hC);
    checkOutput("t4_replay_hwrite", 32'(busIf.HWRITE),    32'd0);
    driveSlave(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("t4_replay_dphase", 32'(busIf.HTRANS),    32'd0);
    checkOutput("t4_rsp_gap",       32'(busIf.rsp_valid), 32'd0);
    driveSlave(1'b1, 1'b0, 32'hCAFE_0001);
    tick();
    checkOutput("t4_rd_rsp_valid",  32'(busIf.rsp_valid), 32'd1);
    checkOutput("t4_rd_rsp_err",    32'(busIf.rsp_err),   32'd0);
    checkOutput("t4_rd_rsp_rdata",  busIf.rsp_rdata,      32'hCAFE_0001);

    $display("[TB] single-cycle ERROR on read 0x10");
    driveSlave(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h10, 32'h0, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    tick();
    driveSlave(1'b1, 1'b1, 32'h5A5A_5A5A);
    tick();
    checkOutput("t4b_rsp_valid",    32'(busIf.rsp_valid), 32'd1);
    checkOutput("t4b_rsp_err",      32'(busIf.rsp_err),   32'd1);
    checkOutput("t4b_rsp_rdata",    busIf.rsp_rdata,      32'h0);
    driveSlave(1'b1, 1'b0, 32'h0);

    $display("[TB] reset during a wait-stated read");
    applyStimulus(1'b1, 32'h20, 32'h0, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b1, 32'h24, 32'h0, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    driveSlave(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t5_htrans_held",   32'(busIf.HTRANS), 32'd2);
    checkOutput("t5_haddr_held",    busIf.HADDR,       32'h24);
    resetN = 1'b0;
    #1;
    checkOutput("t5_htrans_rst",    32'(busIf.HTRANS),    32'd0);
    checkOutput("t5_haddr_rst",     busIf.HADDR,          32'h0);
    checkOutput("t5_rsp_rst",       32'(busIf.rsp_valid), 32'd0);
    driveSlave(1'b1, 1'b0, 32'h1111_2222);
    tick();
    checkOutput("t5_rsp_in_rst1",   32'(busIf.rsp_valid), 32'd0);
    tick();
    checkOutput("t5_rsp_in_rst2",   32'(busIf.rsp_valid), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(1'b1, 32'h30, 32'h0000_0055, 1'b1, 3'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
    checkOutput("t5_new_htrans",    32'(busIf.HTRANS),    32'd2);
    checkOutput("t5_new_haddr",     busIf.HADDR,          32'h30);
    tick();
    checkOutput("t5_new_hwdata",    busIf.HWDATA,         32'h0000_0055);
    checkOutput("t5_new_rsp_early", 32'(busIf.rsp_valid), 32'd0);
    tick();
    checkOutput("t5_new_rsp_valid", 32'(busIf.rsp_valid), 32'd1);
    checkOutput("t5_new_rsp_err",   32'(busIf.rsp_err),   32'd0);

    $display("[TB] word read at misaligned address 0x02");
    driveSlave(1'b1, 1'b0, 32'h0BAD_F00D);
    applyStimulus(1'b1, 32'h2, 32'h0, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
`ifdef AHB_LITE_MASTER_ALIGN_CHECK_EN
    checkOutput("t6_htrans_idle",   32'(busIf.HTRANS),    32'd0);
    checkOutput("t6_rsp_early",     32'(busIf.rsp_valid), 32'd0);
    tick();
    checkOutput("t6_rej_rsp_valid", 32'(busIf.rsp_valid), 32'd1);
    checkOutput("t6_rej_rsp_err",   32'(busIf.rsp_err),   32'd1);
    checkOutput("t6_rej_rsp_rdata", busIf.rsp_rdata,      32'h0);
    checkOutput("t6_htrans_still",  32'(busIf.HTRANS),    32'd0);
    tick();
    checkOutput("t6_rsp_pulse",     32'(busIf.rsp_valid), 32'd0);
    checkOutput("t6_ready_after",   32'(busIf.cmd_ready), 32'd1);
`else
    checkOutput("t6_htrans_nonseq", 32'(busIf.HTRANS),    32'd2);
    checkOutput("t6_haddr",         busIf.HADDR,          32'h2);
    checkOutput("t6_hsize",         32'(busIf.HSIZE),     32'd2);
    tick();
    tick();
    checkOutput("t6_rsp_valid",     32'(busIf.rsp_valid), 32'd1);
    checkOutput("t6_rsp_err",       32'(busIf.rsp_err),   32'd0);
    checkOutput("t6_rsp_rdata",     busIf.rsp_rdata,      32'h0BAD_F00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_fsm.md
Name: ahb_lite_master_fsm

Overview:
- Synthesizable AHB-Lite initiator (manager) that replaces the task-based bench master in real designs.
- Accepts single-transfer commands on a valid/ready interface and drives them onto the AHB-Lite bus with address/data phase pipelining.
- Returns one response per issued command: read data or write acknowledge, plus error flag.
- Sits between a local command source (DMA, CPU bridge, bench sequencer) and AHB_Lite_slave or an interconnect.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on HPROT (data, privileged).
- ADDR_W, 32, address width.
- DATA_W, 32, data bus width.

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data, raw bus lanes; the caller places bytes on the correct lanes
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  HSIZE encoding: Byte = 0, Halfword = 1, Word = 2
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  captured HRDATA; raw 32-bit lane, no shifting; 0 for writes
- rsp_err  out  1  transfer ended with ERROR, or was rejected
- HADDR  out  ADDR_W  AHB address
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size
- HBURST  out  3  always SINGLE (0)
- HPROT  out  4  HPROT_VAL
- HTRANS  out  2  IDLE (0) or NONSEQ (2) only
- HMASTLOCK  out  1  always 0
- HWDATA  out  DATA_W  AHB write data
- HREADY  in  1  bus ready (slave HREADYOUT)
- HRESP  in  1  0 = OKAY, 1 = ERROR
- HRDATA  in  DATA_W  AHB read data

Behaviour:
- Reset (asynchronous, whole block):
  - HTRANS = IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; internal data-phase and replay flags cleared.
  - Any in-flight transfer is dropped with no response. Reset mid-operation is legal.
- cmd_ready = HREADY && !err_first && !replay_valid, where err_first is the first ERROR cycle.
- Address phase: on a rising edge with HREADY = 1:
  - If a command is accepted, load HADDR/HWRITE/HSIZE from it, set HTRANS = NONSEQ, and hold cmd_wdata in an internal register.
  - Otherwise HTRANS = IDLE. HADDR holds its last value.
- Data phase: at the same edge, if the previous HTRANS was NONSEQ:
  - Set dp_valid = 1, dp_write = HWRITE.
  - HWDATA is driven from the held write data during the data phase.
- Back-to-back transfers: a new address phase overlaps the current data phase. Throughput is one transfer per cycle when HREADY stays 1.
- Wait states: while HREADY = 0, every address-phase and data-phase output holds and no command is accepted.
- OKAY completion: edge with dp_valid && HREADY && !HRESP. Next cycle: rsp_valid = 1, rsp_err = 0, rsp_rdata = HRDATA for reads or 0 for writes. Latency from acceptance to rsp_valid is 2 cycles with zero wait states.
- ERROR completion (two-cycle response):
  - Cycle 1 (HRESP = 1, HREADY = 0): if HTRANS = NONSEQ is pending, move it into the replay register and drive HTRANS = IDLE the next cycle.
  - Cycle 2 (HRESP = 1, HREADY = 1): rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - The replay command is reissued as NONSEQ on the following edge, before any new command.
- HRESP = 1 with HREADY = 1 and no preceding HREADY = 0 cycle is still treated as an error completion.
- Responses are never backpressured; the consumer must take every rsp_valid pulse.
- Responses are returned in issue order.

Optional Feature:
- Macro: AHB_LITE_MASTER_ALIGN_CHECK_EN.
- Defined: a command that is misaligned (Halfword with addr[0] = 1; Word with addr[1:0] != 0) or has cmd_size > 2:
  - Is accepted but never issued; HTRANS stays IDLE.
  - Produces rsp_valid = 1, rsp_err = 1 on the next cycle it can occupy response order without colliding with a bus completion. Bus completions take priority; the rejection is queued one cycle.
- Undefined: every command is issued unchanged.

Decomposition:
- Shared package/defines (extends AHB_Lite_defines.v): HTRANS codes IDLE/BUSY/NONSEQ/SEQ; HSIZE Byte/Halfword/Word; HBURST SINGLE; HRESP OKAY/ERROR.
- Sub-module ahb_lite_cmd_replay: single-entry command holding register (addr, wdata, write, size, valid), with load and reissue controls.

Test Plan:
- Write Halfword 0x00 data 0x000000AA, HREADY = 1: NONSEQ with HADDR = 0x00, HSIZE = 1 in cycle N; HWDATA = 0xAA in N+1; rsp_valid, rsp_err = 0 in N+2.
- Read Byte 0x02, slave inserts 2 wait states, HRDATA = 0x00AA0000: HADDR/HTRANS held; rsp_rdata = 0x00AA0000 four cycles after acceptance.
- Back-to-back write Word 0x04 (0xFFFF) then read 0x04: consecutive NONSEQ cycles; responses in order; read returns 0x0000FFFF.
- ERROR on write 0x08 while read 0x0C is pending in address phase: HTRANS goes IDLE; rsp_err = 1 for 0x08; 0x0C reissued as NONSEQ and completes OKAY.
- HRESETn asserted during a wait-stated read: HTRANS = IDLE immediately, no rsp_valid; a new command after release completes normally.
- With AHB_LITE_MASTER_ALIGN_CHECK_EN, Word read at 0x02: no NONSEQ; rsp_valid with rsp_err = 1.
